sha_stream_padder: RTL and testbench

- Streaming SHA-256 message padder for arbitrary-length messages.
- Accepts message bytes as a word stream with valid/ready handshake and emits complete 512-bit padded blocks with their own valid/ready handshake.
- Appends the 0x80 marker, zero fill and 64-bit big-endian bit length, adding an extra block when the length does not fit.
- Sits between the message source and the SHA-256 compression core, replacing fixed-size combinational padding.

---
 rtl/sha_stream_padder.sv | 179 +++++++++++++++++
 tb/tb_sha_stream_padder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_stream_padder.sv
// Streaming SHA-256 padder: packs big-endian message words into 512-bit blocks and appends
// the 0x80 marker, zero fill and bit length, spilling into an extra block when they do not fit.
module sha_stream_padder #(
  parameter int IN_WIDTH   = 32,
  parameter int BLOCK_SIZE = 512,
  parameter int LEN_WIDTH  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IN_WIDTH-1:0]         in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [$clog2(IN_WIDTH/8):0] in_bytes,
  output logic                        in_ready,
  output logic [BLOCK_SIZE-1:0]       blk_data,
  output logic                        blk_valid,
  output logic                        blk_first,
  output logic                        blk_last,
  input  logic                        blk_ready
);

  localparam int WORD_BYTES  = IN_WIDTH / 8;
  localparam int WORDS       = BLOCK_SIZE / IN_WIDTH;
  localparam int BLOCK_BYTES = BLOCK_SIZE / 8;
  localparam int IDX_W       = $clog2(WORDS + 1);
  localparam int FB_W        = $clog2(BLOCK_BYTES + 1);

  typedef enum logic [2:0] {
    FILL,
    PADCALC,
    EMIT,
    EMIT_PRE,
    EMIT_LAST
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BLOCK_SIZE-1:0] blk_buf;
  logic [BLOCK_SIZE-1:0] padded;
  logic [BLOCK_SIZE-1:0] extra;
  logic [IDX_W-1:0]      idx;
  logic [LEN_WIDTH-1:0]  bit_count;
  logic [FB_W-1:0]       fill_bytes;
  logic                  first_flag;
  logic                  marker_done;
  logic                  run;
  logic                  in_fire;
  logic                  blk_fire;
  logic                  len_fits;

  assign in_fire  = in_valid && in_ready;
  assign blk_fire = blk_valid && blk_ready;
  assign blk_data = blk_buf;

  // Length fits when the marker byte plus the whole length field still lie inside this block.
  assign len_fits = (int'(fill_bytes) + 1 + LEN_WIDTH / 8) <= BLOCK_BYTES;

  always_comb begin
    padded = blk_buf;
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      if (FB_W'(b) == fill_bytes) begin
        padded[BLOCK_SIZE-1-8*b -: 8] = 8'h80;
      end else if (FB_W'(b) > fill_bytes) begin
        padded[BLOCK_SIZE-1-8*b -: 8] = 8'h00;
      end
    end
    if (len_fits) begin
      padded[LEN_WIDTH-1:0] = bit_count;
    end
  end

  always_comb begin
    extra                   = '0;
    extra[BLOCK_SIZE-1]     = !marker_done;
    extra[LEN_WIDTH-1:0]    = bit_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    blk_valid  = 1'b0;
    blk_last   = 1'b0;
    case (state)
      FILL: begin
        in_ready = run;
        if (in_valid && run) begin
          if (in_last) begin
            state_next = PADCALC;
          end else if (idx == IDX_W'(WORDS - 1)) begin
            state_next = EMIT;
          end
        end
      end
      PADCALC: state_next = len_fits ? EMIT_LAST : EMIT_PRE;
      EMIT: begin
        blk_valid = 1'b1;
        if (blk_ready) state_next = FILL;
      end
      EMIT_PRE: begin
        blk_valid = 1'b1;
        if (blk_ready) state_next = EMIT_LAST;
      end
      EMIT_LAST: begin
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        if (blk_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    blk_first = blk_valid && first_flag;
  end

  // fill_bytes is only meaningful after the last word: it marks where the marker byte goes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_buf     <= '0;
      idx         <= '0;
      bit_count   <= '0;
      fill_bytes  <= '0;
      first_flag  <= 1'b1;
      marker_done <= 1'b0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        FILL: begin
          if (in_fire) begin
            for (int w = 0; w < WORDS; w++) begin
              if (idx == IDX_W'(w)) begin
                blk_buf[BLOCK_SIZE-1-w*IN_WIDTH -: IN_WIDTH] <= in_data;
              end
            end
            idx        <= idx + 1'b1;
            bit_count  <= bit_count + (in_last ? (LEN_WIDTH'(in_bytes) << 3)
                                               : LEN_WIDTH'(IN_WIDTH));
            fill_bytes <= FB_W'(int'(idx) * WORD_BYTES + int'(in_bytes));
          end
        end
        PADCALC: begin
          blk_buf     <= padded;
          marker_done <= int'(fill_bytes) < BLOCK_BYTES;
        end
        EMIT: begin
          if (blk_fire) begin
            blk_buf    <= '0;
            idx        <= '0;
            first_flag <= 1'b0;
          end
        end
        EMIT_PRE: begin
          if (blk_fire) begin
            blk_buf    <= extra;
            first_flag <= 1'b0;
          end
        end
        EMIT_LAST: begin
          if (blk_fire) begin
            blk_buf     <= '0;
            idx         <= '0;
            bit_count   <= '0;
            fill_bytes  <= '0;
            marker_done <= 1'b0;
            first_flag  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_stream_padder.sv
// Randomized scoreboard bench for sha_stream_padder: a byte-level SHA-256 padding model
// predicts every block; a monitor pops and compares each block the DUT hands over.
`timescale 1ns/1ps
module tb_sha_stream_padder;

  localparam int IN_WIDTH   = 32;
  localparam int BLOCK_SIZE = 512;
  localparam int LEN_WIDTH  = 64;
  localparam int WB         = IN_WIDTH / 8;
  localparam int BW         = $clog2(WB) + 1;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];
  typedef struct {
    logic [BLOCK_SIZE-1:0] data;
    logic                  first;
    logic                  last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic [BW-1:0]         in_bytes;
  logic                  in_ready;
  logic [BLOCK_SIZE-1:0] blk_data;
  logic                  blk_valid;
  logic                  blk_first;
  logic                  blk_last;
  logic                  blk_ready;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   failures   = 0;
  int   ready_mode = 0;
  int   stall_cnt  = 0;
  bit   gap_en     = 1'b0;

  logic                  prev_stalled = 1'b0;
  logic [BLOCK_SIZE-1:0] prev_data;
  logic                  prev_first;
  logic                  prev_last;

  sha_stream_padder #(
    .IN_WIDTH  (IN_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_bytes (in_bytes),
    .in_ready (in_ready),
    .blk_data (blk_data),
    .blk_valid(blk_valid),
    .blk_first(blk_first),
    .blk_last (blk_last),
    .blk_ready(blk_ready)
  );

  always #5 clk = ~clk;

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit big-endian bit length.
  function automatic void push_expected(input bq_t msg);
    bq_t         p;
    logic [63:0] bits;
    exp_t        e;
    int          nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int i = 0; i < 64; i++) e.data[BLOCK_SIZE-1-8*i -: 8] = p[b*64+i];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(byte_t'($urandom));
    return m;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_output({tag, "_blk_valid"}, 64'(blk_valid), 64'd0);
    check_output({tag, "_blk_first"}, 64'(blk_first), 64'd0);
    check_output({tag, "_blk_last"}, 64'(blk_last), 64'd0);
    check_output({tag, "_blk_data_zero"}, 64'(blk_data == '0), 64'd1);
  endtask

  task automatic drive_word(input logic [IN_WIDTH-1:0] word, input logic last, input logic [BW-1:0] nb);
    int waited = 0;
    in_data  = word;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 2000) begin
        checks++;
        failures++;
        $display("[TB] FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // abort_after >= 0 stops after that many words and predicts no blocks for the message.
  task automatic apply_stimulus(input bq_t msg, input int abort_after);
    int n;
    int nw;
    n  = msg.size();
    nw = (n == 0) ? 1 : (n + WB - 1) / WB;
    if (abort_after < 0) push_expected(msg);
    for (int w = 0; w < nw; w++) begin
      logic [IN_WIDTH-1:0] word;
      logic                last;
      logic [BW-1:0]       nb;
      int                  pos;
      if (abort_after >= 0 && w == abort_after) return;
      if (gap_en && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      for (int k = 0; k < WB; k++) begin
        pos = w * WB + k;
        word[IN_WIDTH-1-8*k -: 8] = (pos < n) ? msg[pos] : byte_t'($urandom);
      end
      last = (w == nw - 1);
      nb   = last ? BW'(n - w * WB) : BW'($urandom_range(0, WB));
      drive_word(word, last, nb);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check_output({tag, "_drain_pending"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && in_valid && in_last)
      assert (in_bytes <= WB) else $error("[TB] illegal in_bytes %0d", in_bytes);
  end

  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: blk_ready = 1'b1;
        1: blk_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (!blk_valid) begin
            stall_cnt = 0;
            blk_ready = 1'b0;
          end else if (stall_cnt < 10) begin
            blk_ready = 1'b0;
            stall_cnt++;
          end else begin
            blk_ready = 1'b1;
            stall_cnt = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compares every transferred block and checks that stalled blocks stay frozen.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stalled = 1'b0;
    end else if (blk_valid) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL in_ready_during_emit: got %0b expected 0", in_ready);
      end
      if (prev_stalled) begin
        checks++;
        if (blk_data !== prev_data || blk_first !== prev_first || blk_last !== prev_last) begin
          failures++;
          $display("[TB] FAIL hold: got first=%0b last=%0b data=%0h expected first=%0b last=%0b data=%0h",
                   blk_first, blk_last, blk_data, prev_first, prev_last, prev_data);
        end
      end
      if (blk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_block: got data=%0h expected no block", blk_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (blk_data !== mon_e.data || blk_first !== mon_e.first || blk_last !== mon_e.last) begin
            failures++;
            $display("[TB] FAIL block: got first=%0b last=%0b data=%0h expected first=%0b last=%0b data=%0h",
                     blk_first, blk_last, blk_data, mon_e.first, mon_e.last, mon_e.data);
          end
        end
        prev_stalled = 1'b0;
      end else begin
        prev_stalled = 1'b1;
        prev_data    = blk_data;
        prev_first   = blk_first;
        prev_last    = blk_last;
      end
    end else begin
      prev_stalled = 1'b0;
    end
  end

  initial begin
    bq_t abc;
    abc = '{8'h61, 8'h62, 8'h63};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = '0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check_output("in_ready_after_edge", 64'(in_ready), 64'd1);

    $display("[TB] directed lengths: abc, empty, 55, 56, 64 bytes");
    apply_stimulus(abc, -1);
    apply_stimulus(rand_msg(0), -1);
    apply_stimulus(rand_msg(55), -1);
    apply_stimulus(rand_msg(56), -1);
    apply_stimulus(rand_msg(64), -1);
    wait_drain("directed");

    $display("[TB] ten-cycle stall at every block");
    ready_mode = 2;
    apply_stimulus(rand_msg(64), -1);
    apply_stimulus(rand_msg(56), -1);
    apply_stimulus(abc, -1);
    wait_drain("stall");

    $display("[TB] random lengths with input gaps and random backpressure");
    ready_mode = 1;
    gap_en     = 1'b1;
    for (int i = 0; i < 12; i++) apply_stimulus(rand_msg($urandom_range(0, 150)), -1);
    wait_drain("random");

    $display("[TB] reset in the middle of a 20-word message");
    ready_mode = 0;
    gap_en     = 1'b0;
    apply_stimulus(rand_msg(80), 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(abc, -1);
    wait_drain("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
